// File: rtl/noc_ni.sv
// Core-side network interface running in loopback: core writes are queued as
// {addr, data} packets in write_fifo and popped back through the read port.
module noc_ni #(
    parameter int unsigned ADDRSIZE = 5,
    parameter int unsigned MSB_SLOT = 5,
    localparam int unsigned RSIZE   = 1 << (MSB_SLOT - 1),
    localparam int unsigned DSIZE   = 1 << MSB_SLOT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RSIZE-1:0] core_write_data,
    input  logic [RSIZE-1:0] core_write_addr,
    input  logic             core_write_en,
    input  logic             core_read_en,
    output logic [RSIZE-1:0] core_read_data
);

    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    // write_fifo storage; contents are not cleared by reset
    logic [DSIZE-1:0] fifo_ff [DEPTH];

    // Extra MSB on each pointer separates full from empty
    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] rptr;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        empty   = (wptr == rptr);
        full    = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                  (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
        do_push = core_write_en && !full;
        do_pop  = core_read_en && !empty;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_ff[wptr[ADDRSIZE-1:0]] <= {core_write_addr, core_write_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr           <= '0;
            rptr           <= '0;
            core_read_data <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                core_read_data <= fifo_ff[rptr[ADDRSIZE-1:0]][RSIZE-1:0];
                rptr           <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_ni.sv
// Directed self-checking bench for noc_ni in loopback mode.
module tb_noc_ni;

    logic        clk;
    logic        reset;
    logic [15:0] core_write_data;
    logic [15:0] core_write_addr;
    logic        core_write_en;
    logic        core_read_en;
    logic [15:0] core_read_data;

    int checks;
    int failures;

    noc_ni #(
        .ADDRSIZE(5),
        .MSB_SLOT(5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .core_write_data(core_write_data),
        .core_write_addr(core_write_addr),
        .core_write_en  (core_write_en),
        .core_read_en   (core_read_en),
        .core_read_data (core_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, return #1 after it
    task automatic cyc(input logic we, input logic re, input logic [15:0] a,
                       input logic [15:0] d);
        core_write_en   = we;
        core_read_en    = re;
        core_write_addr = a;
        core_write_data = d;
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        core_read_en  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [5:0] occ;

    initial begin
        checks          = 0;
        failures        = 0;
        core_write_en   = 1'b0;
        core_read_en    = 1'b0;
        core_write_addr = '0;
        core_write_data = '0;
        reset           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", 32'(core_read_data), 32'h0);
        check("rst_empty", 32'(dut.empty), 32'h1);
        reset = 1'b1;

        // 1: single write then read
        cyc(1'b1, 1'b0, 16'hA5A5, 16'hAAAA);
        check("t1_entry0", dut.fifo_ff[0], 32'hA5A5AAAA);
        check("t1_wptr", 32'(dut.wptr), 32'h1);
        cyc(1'b0, 1'b1, 16'h0, 16'h0);
        check("t1_rdata", 32'(core_read_data), 32'hAAAA);
        check("t1_empty", 32'(dut.empty), 32'h1);

        // 2: empty reads, then push+pop on empty (push only)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 16'h0, 16'h0);
            check("t2_rdata", 32'(core_read_data), 32'h0);
            check("t2_ptrs", {26'h0, dut.wptr} | 32'(dut.rptr), 32'h0);
        end
        cyc(1'b1, 1'b1, 16'h0001, 16'h7777);
        check("t2_bypass_rdata", 32'(core_read_data), 32'h0);
        check("t2_bypass_wptr", 32'(dut.wptr), 32'h1);
        cyc(1'b0, 1'b1, 16'h0, 16'h0);
        check("t2_after_rdata", 32'(core_read_data), 32'h7777);

        // 3: fill, overflow, drain
        do_reset();
        for (int i = 0; i < 33; i++) begin
            cyc(1'b1, 1'b0, 16'(16'h0100 + i), 16'(i));
        end
        check("t3_full", 32'(dut.full), 32'h1);
        check("t3_wptr", 32'(dut.wptr), 32'd32);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 16'h0, 16'h0);
            check("t3_drain", 32'(core_read_data), 32'(i));
        end
        cyc(1'b0, 1'b1, 16'h0, 16'h0);
        check("t3_extra_read", 32'(core_read_data), 32'd31);
        check("t3_empty", 32'(dut.empty), 32'h1);

        // 4: wrap-around, pointers start at 32
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 20; i++) begin
                cyc(1'b1, 1'b0, 16'hBEEF, 16'(16'h4000 + r * 256 + i));
            end
            for (int i = 0; i < 20; i++) begin
                cyc(1'b0, 1'b1, 16'h0, 16'h0);
                check("t4_wrap", 32'(core_read_data), 32'(16'h4000 + r * 256 + i));
            end
        end
        check("t4_rptr", 32'(dut.rptr), 32'd8);

        // 5: simultaneous push and pop with one entry
        cyc(1'b1, 1'b0, 16'h0005, 16'h1111);
        cyc(1'b1, 1'b1, 16'h0005, 16'h2222);
        check("t5_rdata", 32'(core_read_data), 32'h1111);
        occ = dut.wptr - dut.rptr;
        check("t5_occ", 32'(occ), 32'h1);
        cyc(1'b0, 1'b1, 16'h0, 16'h0);
        check("t5_second", 32'(core_read_data), 32'h2222);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'h0006, 16'(16'h6000 + i));
        end
        #2;
        reset = 1'b0;
        #1;
        check("t6_rdata", 32'(core_read_data), 32'h0);
        check("t6_empty", 32'(dut.empty), 32'h1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 16'h0, 16'h0);
        check("t6_post_read", 32'(core_read_data), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
